irq_ctrl: RTL and testbench

- Memory-mapped interrupt controller between the interrupt sources (timer IRQ0, timer IRQ1, external interrupt line) and the CPU's 6-bit HWInt input.
- Latches source events as pending bits and applies a per-source mask and per-source edge/level mode.
- Drives a registered HWInt vector to the CPU.
- Accessed through the bridge like a timer: word address, bridge-decoded write enable, write data, combinational read data.

---
 rtl/irq_ctrl_if.sv | 14 +
 rtl/irq_ctrl.sv | 85 ++++++++
 tb/tb_irq_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// Bus-side register port of the interrupt controller: word address,
// decoded write strobe, write data and combinational read data.
interface irq_ctrl_if;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    // Bridge side drives the access, reads back Dout
    modport master (output Addr, output WE, output Din, input Dout);

    // Controller side decodes the access and returns read data
    modport slave (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches source events into pending bits with
// per-source edge/level mode and mask, counts newly raised enabled events,
// and drives a registered masked-pending vector to the CPU HWInt input.
module irq_ctrl #(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    irq_ctrl_if.slave       bus,
    input  logic [NSRC-1:0] irq_src,
    output logic [NSRC-1:0] HWInt
);

    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_MODE = 2'd2;
    localparam logic [1:0] REG_ICNT = 2'd3;

    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] mode;
    logic [NSRC-1:0] prev;
    logic [31:0]     icnt;

    logic [1:0]      sel;
    logic            wr_pend;
    logic            wr_mask;
    logic            wr_mode;
    logic            wr_icnt;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] pend_edge;
    logic [NSRC-1:0] pend_next;
    logic [NSRC-1:0] new_set;

    // Upper address bits are decoded by the bridge and intentionally ignored here
    logic unused_addr;
    assign unused_addr = ^bus.Addr[29:2];

    // Decode the access and compute next pending state; a rise beats a same-cycle clear
    always_comb begin
        sel       = bus.Addr[1:0];
        wr_pend   = bus.WE && (sel == REG_PEND);
        wr_mask   = bus.WE && (sel == REG_MASK);
        wr_mode   = bus.WE && (sel == REG_MODE);
        wr_icnt   = bus.WE && (sel == REG_ICNT);
        rise      = irq_src & ~prev;
        w1c       = wr_pend ? bus.Din[NSRC-1:0] : '0;
        pend_edge = rise | (pend & ~w1c);
        pend_next = (mode & pend_edge) | (~mode & irq_src);
        new_set   = pend_next & ~pend & mask;
    end

    // Register state; reset overrides writes and source activity
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend  <= '0;
            mask  <= '0;
            mode  <= '0;
            prev  <= '0;
            icnt  <= '0;
            HWInt <= '0;
        end else begin
            prev  <= irq_src;
            pend  <= pend_next;
            HWInt <= pend & mask;
            if (wr_mask) mask <= bus.Din[NSRC-1:0];
            if (wr_mode) mode <= bus.Din[NSRC-1:0];
            if (wr_icnt)       icnt <= bus.Din;
            else if (|new_set) icnt <= icnt + 32'd1;
        end
    end

    // Combinational read mux; narrow registers are zero-extended
    always_comb begin
        bus.Dout = '0;
        case (sel)
            REG_PEND: bus.Dout = 32'(pend);
            REG_MASK: bus.Dout = 32'(mask);
            REG_MODE: bus.Dout = 32'(mode);
            default:  bus.Dout = icnt;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expected values are queued when stimulus is
// applied and popped when the corresponding DUT output is observed.
module tb_irq_ctrl;
    logic       clk;
    logic       reset;
    logic [5:0] irq_src;
    logic [5:0] HWInt;

    irq_ctrl_if bus();

    irq_ctrl #(.NSRC(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .irq_src (irq_src),
        .HWInt   (HWInt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty obs=%h exp=none", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.v) else begin
                bad++;
                $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.Addr = {28'd0, a};
        bus.WE   = 1'b1;
        bus.Din  = d;
        tick();
        bus.WE   = 1'b0;
        bus.Din  = '0;
    endtask

    task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        push(tag, exp);
        bus.Addr = {28'd0, a};
        #1;
        pop_chk(bus.Dout);
    endtask

    task automatic hwchk(input string tag, input logic [5:0] exp);
        push(tag, {26'd0, exp});
        pop_chk({26'd0, HWInt});
    endtask

    initial begin
        bus.Addr = '0;
        bus.WE   = 1'b0;
        bus.Din  = '0;
        irq_src  = 6'h3F;
        reset    = 1'b0;

        // Reset with all sources active
        tick();
        tick();
        hwchk("rst_hwint", 6'h00);
        rdchk("rst_pend", 2'd0, 32'h0);
        rdchk("rst_mask", 2'd1, 32'h0);
        rdchk("rst_mode", 2'd2, 32'h0);
        rdchk("rst_icnt", 2'd3, 32'h0);
        reset = 1'b1;
        tick();
        rdchk("lvl_pend_after_rst", 2'd0, 32'h3F);
        hwchk("lvl_hwint_masked", 6'h00);
        rdchk("lvl_icnt_masked", 2'd3, 32'h0);
        irq_src = 6'h00;
        tick();

        // Edge-mode pulse on source 0
        wr(2'd1, 32'h01);
        wr(2'd2, 32'h01);
        rdchk("mask_rb", 2'd1, 32'h01);
        rdchk("mode_rb", 2'd2, 32'h01);
        irq_src = 6'h01;
        tick();
        rdchk("edge_pend_set", 2'd0, 32'h01);
        hwchk("edge_hw_lat1", 6'h00);
        irq_src = 6'h00;
        tick();
        hwchk("edge_hw_lat2", 6'h01);
        rdchk("edge_icnt1", 2'd3, 32'h1);
        tick();
        tick();
        rdchk("edge_pend_hold", 2'd0, 32'h01);
        wr(2'd0, 32'h01);
        rdchk("w1c_pend", 2'd0, 32'h00);
        hwchk("w1c_hw_still", 6'h01);
        tick();
        hwchk("w1c_hw_drop", 6'h00);

        // Simultaneous rise and clear: set wins, no count
        irq_src = 6'h01;
        tick();
        rdchk("rise2_icnt", 2'd3, 32'h2);
        irq_src = 6'h00;
        tick();
        irq_src = 6'h01;
        wr(2'd0, 32'h01);
        rdchk("setwin_pend", 2'd0, 32'h01);
        rdchk("setwin_icnt", 2'd3, 32'h2);
        irq_src = 6'h00;
        wr(2'd0, 32'h01);
        tick();
        hwchk("setwin_clr_hw", 6'h00);

        // Level mode on source 2, held 5 cycles, W1C ignored
        wr(2'd1, 32'h04);
        irq_src = 6'h04;
        for (int n = 1; n <= 8; n++) begin
            if (n == 3) begin
                bus.Addr = '0;
                bus.WE   = 1'b1;
                bus.Din  = 32'h04;
            end
            push("lvl_hw", (n >= 2 && n <= 6) ? 32'h04 : 32'h00);
            tick();
            bus.WE  = 1'b0;
            bus.Din = '0;
            pop_chk({26'd0, HWInt});
            rdchk("lvl_pend", 2'd0, (n <= 5) ? 32'h04 : 32'h00);
            if (n == 5) irq_src = 6'h00;
        end
        rdchk("lvl_icnt", 2'd3, 32'h3);

        // ICNT wrap and write-over-increment
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd1, 32'h05);
        rdchk("icnt_load", 2'd3, 32'hFFFF_FFFF);
        irq_src = 6'h01;
        tick();
        rdchk("icnt_wrap", 2'd3, 32'h0);
        irq_src = 6'h00;
        wr(2'd0, 32'h01);
        tick();
        irq_src = 6'h01;
        wr(2'd3, 32'h5);
        rdchk("icnt_wr_wins", 2'd3, 32'h5);
        rdchk("icnt_wr_pend", 2'd0, 32'h01);
        irq_src = 6'h00;
        wr(2'd0, 32'h01);
        tick();

        // Two simultaneous rises count once; unmasked source only pends
        wr(2'd1, 32'h03);
        wr(2'd2, 32'h03);
        irq_src = 6'h03;
        tick();
        irq_src = 6'h00;
        tick();
        hwchk("dual_hw", 6'h03);
        rdchk("dual_icnt", 2'd3, 32'h6);
        wr(2'd0, 32'h03);
        tick();
        wr(2'd1, 32'h01);
        irq_src = 6'h02;
        tick();
        irq_src = 6'h00;
        tick();
        rdchk("unmasked_pend", 2'd0, 32'h02);
        hwchk("unmasked_hw", 6'h00);
        rdchk("unmasked_icnt", 2'd3, 32'h6);

        // Upper register bits ignore writes
        wr(2'd2, 32'hFFFF_FFC0);
        rdchk("mode_upper", 2'd2, 32'h00);

        // Reset beats a same-cycle write
        reset = 1'b0;
        wr(2'd3, 32'h7);
        rdchk("rst_vs_wr_icnt", 2'd3, 32'h0);
        rdchk("rst_vs_wr_pend", 2'd0, 32'h0);
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
